// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR sequencer slice.
package sar_pkg;

  typedef enum logic [1:0] {IDLE, START, WAIT, PACE} state_t;

  localparam int SAR_N = 8;

  function automatic int acc_width(input int n, input int log2_avg);
    return n + log2_avg;
  endfunction

endpackage

// File: rtl/sar_accumulator.sv
// Sums 2^LOG2_AVG captured results and holds each average on a valid/ready port.
module sar_accumulator
  import sar_pkg::*;
#(
  parameter int N        = SAR_N,
  parameter int LOG2_AVG = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         capture,
  input  logic         clear,
  input  logic [N-1:0] adc_result,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  output logic         overrun
);

  localparam int AW = acc_width(N, LOG2_AVG);
  // A one-bit counter that never advances stands in for LOG2_AVG=0 (pass-through).
  localparam int CW = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_AVG) - 1);

  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic [CW-1:0] cnt;
  logic          last;

  assign sum  = acc + AW'(adc_result);
  assign last = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (capture) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end
  end

  // A consumer handshake in the same cycle as a new average absorbs the old one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (capture && last) begin
        out_data  <= N'(sum >> LOG2_AVG);
        out_valid <= 1'b1;
        overrun   <= out_valid && !out_ready;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sar_sequencer.sv
// Paces SAR conversions with a periodic go pulse and averages the results.
// Define SAR_SEQ_TIMEOUT_EN to build the WAIT timeout that re-issues go and pulses err.
module sar_sequencer
  import sar_pkg::*;
#(
  parameter int N        = SAR_N,
  parameter int LOG2_AVG = 2,
  parameter int PERIOD   = 32,
  parameter int TIMEOUT  = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic         go,
  input  logic         adc_valid,
  input  logic [N-1:0] adc_result,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         overrun,
  output logic         err
);

  localparam int PW = $clog2(PERIOD);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD - 1);

  state_t        state;
  state_t        next_state;
  logic          valid_q;
  logic          valid_rise;
  logic          timed_out;
  logic          capture;
  logic          clear;
  logic [PW-1:0] period_cnt;

  assign valid_rise = adc_valid && !valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      valid_q <= 1'b0;
    end else begin
      state   <= next_state;
      valid_q <= adc_valid;
    end
  end

  // The go cycle itself counts as cycle 0, so the count restarts at 1 after it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_cnt <= '0;
    end else if (state == START) begin
      period_cnt <= PW'(1);
    end else if (period_cnt != PERIOD_LAST) begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

`ifdef SAR_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign timed_out = (state == WAIT) && (wait_cnt == TIMEOUT_LAST);
`else
  // TIMEOUT has no effect when the timer is not built.
  assign timed_out = 1'b0 & (TIMEOUT > 0);
`endif

  always_comb begin
    next_state = state;
    go         = 1'b0;
    err        = 1'b0;
    capture    = 1'b0;
    clear      = 1'b0;
    case (state)
      IDLE: begin
        if (en) next_state = START;
      end
      START: begin
        go         = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (valid_rise) begin
          capture    = 1'b1;
          next_state = PACE;
        end else if (timed_out) begin
          err        = 1'b1;
          next_state = START;
        end
      end
      PACE: begin
        if (!en) begin
          clear      = 1'b1;
          next_state = IDLE;
        end else if (period_cnt >= PERIOD_LAST) begin
          next_state = START;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  sar_accumulator #(
    .N        (N),
    .LOG2_AVG (LOG2_AVG)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture),
    .clear      (clear),
    .adc_result (adc_result),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .overrun    (overrun)
  );

endmodule
